// File: rtl/riscv_pipe_stage.sv
// Purpose: DEPTH-entry valid/ready pipeline stage (circular buffer) with a pipeline-kill flush.
// Latency: one edge from push to out_valid when empty; out_data comes from storage, never from in_data.
// Backpressure: in_ready when not full, or when full and out_ready (READY_PASS=1); low during flush.
module riscv_pipe_stage #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter int READY_PASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  // A single-entry stage still needs a one-bit pointer so the declarations stay legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam bit               PASS     = (READY_PASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             not_full;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths never index a missing entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode; in_ready looks only at occupancy, out_ready and flush, never at in_valid.
  always_comb begin
    not_full  = (cnt_q < FULL_CNT);
    out_valid = (cnt_q != '0);
    in_ready  = !flush && (not_full || (PASS && out_ready));
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Head entry is read straight from storage; it is don't-care while out_valid is low.
  always_comb begin
    out_data = mem[rd_ptr];
    count    = cnt_q;
  end

  // Occupancy and pointers; reset overrides flush, and flush overrides any push/pop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      cnt_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage carries no reset; a write during a reset cycle is orphaned by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Bench for riscv_pipe_stage: five configurations share one clock, each with its own inputs.
// A queue per instance holds accepted payloads; every cycle the outputs are compared against it.
// Instances: 0 D2/pass, 1 D2/no-pass, 2 D3/pass, 3 D4/pass, 4 D1/no-pass.
module tb_riscv_pipe_stage;

  localparam int N = 5;
  localparam int DEP [N] = '{2, 2, 3, 4, 1};
  localparam int RP  [N] = '{1, 0, 1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rs   [N];
  logic        fl   [N];
  logic        iv   [N];
  logic        ordy [N];
  logic [31:0] din  [N];

  logic [N-1:0]       irdy;
  logic [N-1:0]       ovld;
  logic [N-1:0][31:0] dout;
  logic [1:0] cnt0, cnt1, cnt2;
  logic [2:0] cnt3;
  logic       cnt4;
  int         cnt [N];

  always_comb begin
    cnt[0] = int'(cnt0);
    cnt[1] = int'(cnt1);
    cnt[2] = int'(cnt2);
    cnt[3] = int'(cnt3);
    cnt[4] = int'(cnt4);
  end

  riscv_pipe_stage #(.WIDTH(32), .DEPTH(2), .READY_PASS(1)) u_d2p1 (
    .clk(clk), .rst(rs[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_data(din[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_data(dout[0]), .count(cnt0));
  riscv_pipe_stage #(.WIDTH(32), .DEPTH(2), .READY_PASS(0)) u_d2p0 (
    .clk(clk), .rst(rs[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_data(din[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_data(dout[1]), .count(cnt1));
  riscv_pipe_stage #(.WIDTH(32), .DEPTH(3), .READY_PASS(1)) u_d3p1 (
    .clk(clk), .rst(rs[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_data(din[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_data(dout[2]), .count(cnt2));
  riscv_pipe_stage #(.WIDTH(32), .DEPTH(4), .READY_PASS(1)) u_d4p1 (
    .clk(clk), .rst(rs[3]), .flush(fl[3]), .in_valid(iv[3]), .in_ready(irdy[3]),
    .in_data(din[3]), .out_valid(ovld[3]), .out_ready(ordy[3]), .out_data(dout[3]), .count(cnt3));
  riscv_pipe_stage #(.WIDTH(32), .DEPTH(1), .READY_PASS(0)) u_d1p0 (
    .clk(clk), .rst(rs[4]), .flush(fl[4]), .in_valid(iv[4]), .in_ready(irdy[4]),
    .in_data(din[4]), .out_valid(ovld[4]), .out_ready(ordy[4]), .out_data(dout[4]), .count(cnt4));

  logic [31:0] sbq [N][$];
  int          hs  [N];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare outputs to the queues, advance the queues, step to the next negedge.
  task automatic tick();
    logic exp_rdy;
    int   mc;
    #1;
    for (int k = 0; k < N; k++) begin
      mc      = sbq[k].size();
      exp_rdy = !fl[k] && ((mc < DEP[k]) || ((RP[k] != 0) && ordy[k]));
      chk($sformatf("u%0d in_ready", k), 32'(irdy[k]), 32'(exp_rdy));
      chk($sformatf("u%0d out_valid", k), 32'(ovld[k]), 32'(mc != 0));
      chk($sformatf("u%0d count", k), 32'(cnt[k]), 32'(mc));
      if (mc != 0) chk($sformatf("u%0d out_data", k), dout[k], sbq[k][0]);
      if (iv[k] && irdy[k]) hs[k]++;
      if (mc != 0 && ordy[k]) void'(sbq[k].pop_front());
      if (rs[k] || fl[k]) sbq[k].delete();
      else if (iv[k] && exp_rdy) sbq[k].push_back(din[k]);
    end
    @(negedge clk);
  endtask

  task automatic push_n(input int k, input logic [31:0] d);
    iv[k]  = 1'b1;
    din[k] = d;
    tick();
    iv[k]  = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rs[k] = 1'b1; fl[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0; hs[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) rs[k] = 1'b0;
    tick();  // reset state: count 0, out_valid 0, in_ready 1 for all

    // Back-to-back stream through a two-deep stage with the sink always ready.
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    din[0] = 32'h11; tick(); chk("s1 count a", 32'(cnt[0]), 1); chk("s1 head a", dout[0], 32'h11);
    din[0] = 32'h22; tick(); chk("s1 count b", 32'(cnt[0]), 1); chk("s1 head b", dout[0], 32'h22);
    din[0] = 32'h33; tick(); chk("s1 count c", 32'(cnt[0]), 1); chk("s1 head c", dout[0], 32'h33);
    iv[0] = 1'b0; tick(); chk("s1 drained", 32'(cnt[0]), 0);
    ordy[0] = 1'b0;

    // No pass-through: full stage refuses 0xC until the sink drains it.
    push_n(1, 32'hA);
    push_n(1, 32'hB);
    chk("s2 full count", 32'(cnt[1]), 2);
    iv[1] = 1'b1; din[1] = 32'hC; #1;
    chk("s2 in_ready low", 32'(irdy[1]), 0);
    tick();
    iv[1] = 1'b0; ordy[1] = 1'b1;
    chk("s2 head A", dout[1], 32'hA); tick();
    chk("s2 head B", dout[1], 32'hB); tick();
    chk("s2 in_ready back", 32'(irdy[1]), 1);
    chk("s2 empty", 32'(cnt[1]), 0);
    ordy[1] = 1'b0;

    // Pass-through: full stage pops 0xA and takes 0xC in the same cycle.
    push_n(0, 32'hA);
    push_n(0, 32'hB);
    iv[0] = 1'b1; din[0] = 32'hC; ordy[0] = 1'b1; #1;
    chk("s3 in_ready full", 32'(irdy[0]), 1);
    tick();
    iv[0] = 1'b0;
    chk("s3 count", 32'(cnt[0]), 2); chk("s3 head B", dout[0], 32'hB); tick();
    chk("s3 head C", dout[0], 32'hC); tick();
    chk("s3 empty", 32'(cnt[0]), 0);
    ordy[0] = 1'b0;

    // Flush of a full three-deep stage with a competing push, then refill across the wrap.
    push_n(2, 32'd1);
    push_n(2, 32'd2);
    push_n(2, 32'd3);
    fl[2] = 1'b1; iv[2] = 1'b1; din[2] = 32'd4; #1;
    chk("s4 in_ready flush", 32'(irdy[2]), 0);
    tick();
    fl[2] = 1'b0; iv[2] = 1'b0;
    chk("s4 count flushed", 32'(cnt[2]), 0);
    chk("s4 valid flushed", 32'(ovld[2]), 0);
    push_n(2, 32'd5);
    chk("s4 head 5", dout[2], 32'd5);
    chk("s4 count 1", 32'(cnt[2]), 1);
    ordy[2] = 1'b1; tick(); ordy[2] = 1'b0;
    for (int i = 6; i <= 8; i++) push_n(2, 32'(i));
    ordy[2] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ordy[2] = 1'b0;

    // Random valid/ready traffic on the three-deep stage.
    hs[2] = 0;
    for (int i = 0; i < 10000; i++) begin
      iv[2]   = ($urandom_range(0, 3) != 0);
      ordy[2] = ($urandom_range(0, 3) != 0);
      din[2]  = $urandom;
      tick();
    end
    iv[2] = 1'b0; ordy[2] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("s5 enough traffic", 32'(hs[2] > 5000), 1);
    chk("s5 drained", 32'(cnt[2]), 0);
    ordy[2] = 1'b0;

    // Reset mid-stream beats flush and push; first post-reset push is the first output.
    push_n(3, 32'h31);
    push_n(3, 32'h32);
    push_n(3, 32'h33);
    rs[3] = 1'b1; fl[3] = 1'b1; iv[3] = 1'b1; din[3] = 32'h99;
    tick();
    rs[3] = 1'b0; fl[3] = 1'b0; iv[3] = 1'b0;
    chk("s6 count reset", 32'(cnt[3]), 0);
    chk("s6 valid reset", 32'(ovld[3]), 0);
    push_n(3, 32'h77);
    chk("s6 first out", dout[3], 32'h77);
    ordy[3] = 1'b1; tick();
    chk("s6 empty", 32'(cnt[3]), 0);

    // Full rate on a deep stage with the sink always ready.
    hs[3] = 0; iv[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din[3] = 32'(100 + i);
      tick();
    end
    iv[3] = 1'b0; tick();
    chk("s7 full rate", 32'(hs[3]), 20);
    ordy[3] = 1'b0;

    // Single entry without pass-through can only move every other cycle.
    hs[4] = 0; iv[4] = 1'b1; ordy[4] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din[4] = 32'(200 + i);
      tick();
    end
    iv[4] = 1'b0; tick();
    chk("s8 half rate", 32'(hs[4]), 10);
    ordy[4] = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
